ex_alu_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline.
- Accepts a decoded ID/EX bundle and selects ALU operands: rs1/PC for A, rs2/imm for B.
- Computes the RV32I integer ALU result, including arithmetic right shift.
- Holds the result in a single-entry EX/MEM register with valid/ready handshake, stall back-pressure and flush.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_32.sv | 36 +++
 rtl/sra_32.sv | 8 +
 rtl/ex_alu_stage.sv | 67 ++++++
 tb/tb_ex_alu_stage.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op and forwarding-select encodings shared by the execute stage.
package alu_pkg;
  localparam int ALU_OP_W = 4;
  localparam int FWD_SEL_W = 2;
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_RF3 = 2'd3
  } fwd_sel_e;
endpackage

// File: rtl/alu_32.sv
// alu_32: combinational RV32I ALU; op codes 11-15 yield zero.
module alu_32 import alu_pkg::*; (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [31:0]         y
);
  logic [31:0] sll_y, srl_y, sra_y;
  sra_32 u_sra (.a(a), .sh(b[4:0]), .y(sra_y));
  // log2 barrel stages; only b[4:0] steer the shift
  always_comb begin
    sll_y = a;
    srl_y = a;
    for (int i = 0; i < 5; i++) begin
      sll_y = b[i] ? sll_y << (1 << i) : sll_y;
      srl_y = b[i] ? srl_y >> (1 << i) : srl_y;
    end
  end
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = sll_y;
      ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'b0, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = srl_y;
      ALU_SRA:   y = sra_y;
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end
endmodule

// File: rtl/sra_32.sv
// sra_32: 32-bit arithmetic right shift, sign-filled from a[31].
module sra_32 (
  input  logic [31:0] a,
  input  logic [4:0]  sh,
  output logic [31:0] y
);
  assign y = $signed(a) >>> sh;
endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: RV32I execute stage with single-entry EX/MEM register; define EX_FWD_EN for operand forwarding.
module ex_alu_stage import alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RADDR_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [XLEN-1:0]     i_rs1_data,
  input  logic [XLEN-1:0]     i_rs2_data,
  input  logic [XLEN-1:0]     i_imm,
  input  logic                i_op_a_sel,
  input  logic                i_op_b_sel,
  input  logic [ALU_OP_W-1:0] i_alu_op,
  input  logic [RADDR_W-1:0]  i_rd_addr,
  input  logic                i_rd_wren,
`ifdef EX_FWD_EN
  input  logic [FWD_SEL_W-1:0] i_fwd_a_sel,
  input  logic [FWD_SEL_W-1:0] i_fwd_b_sel,
  input  logic [XLEN-1:0]      i_mem_fwd_data,
  input  logic [XLEN-1:0]      i_wb_fwd_data,
`endif
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [XLEN-1:0]     o_alu_result,
  output logic [XLEN-1:0]     o_store_data,
  output logic [RADDR_W-1:0]  o_rd_addr,
  output logic                o_rd_wren
);
  logic [XLEN-1:0] rs1, rs2, op_a, op_b, alu_y;
  logic fire;
`ifdef EX_FWD_EN
  assign rs1 = i_fwd_a_sel == FWD_MEM ? i_mem_fwd_data : i_fwd_a_sel == FWD_WB ? i_wb_fwd_data : i_rs1_data;
  assign rs2 = i_fwd_b_sel == FWD_MEM ? i_mem_fwd_data : i_fwd_b_sel == FWD_WB ? i_wb_fwd_data : i_rs2_data;
`else
  assign rs1 = i_rs1_data;
  assign rs2 = i_rs2_data;
`endif
  assign op_a = i_op_a_sel ? i_pc : rs1;
  assign op_b = i_op_b_sel ? i_imm : rs2;
  assign o_in_ready = !o_out_valid || i_out_ready;
  assign fire = i_in_valid && o_in_ready;
  alu_32 u_alu (.op(i_alu_op), .a(op_a), .b(op_b), .y(alu_y));
  // flush only kills valid; the data registers keep their last contents
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid  <= 1'b0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_rd_addr    <= '0;
      o_rd_wren    <= 1'b0;
    end else if (i_flush) begin
      o_out_valid <= 1'b0;
    end else if (fire) begin
      o_out_valid  <= 1'b1;
      o_alu_result <= alu_y;
      o_store_data <= rs2;
      o_rd_addr    <= i_rd_addr;
      o_rd_wren    <= i_rd_wren && |i_rd_addr;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed self-checking bench for ex_alu_stage.
module tb_ex_alu_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [31:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
  logic a_sel = 1'b0, b_sel = 1'b0;
  logic [3:0] op = '0;
  logic [4:0] rd = '0;
  logic rd_wren = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] alu_result, store_data;
  logic [4:0] rd_addr_q;
  logic rd_wren_q;
`ifdef EX_FWD_EN
  logic [1:0] fwd_a = '0, fwd_b = '0;
  logic [31:0] mem_fwd = '0, wb_fwd = '0;
`endif
  int vectors = 0, miscompares = 0;

  ex_alu_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm(imm),
    .i_op_a_sel(a_sel), .i_op_b_sel(b_sel), .i_alu_op(op), .i_rd_addr(rd), .i_rd_wren(rd_wren),
`ifdef EX_FWD_EN
    .i_fwd_a_sel(fwd_a), .i_fwd_b_sel(fwd_b), .i_mem_fwd_data(mem_fwd), .i_wb_fwd_data(wb_fwd),
`endif
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_alu_result(alu_result),
    .o_store_data(store_data), .o_rd_addr(rd_addr_q), .o_rd_wren(rd_wren_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic bs, input logic [31:0] im, input logic [4:0] r, input logic w);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b; b_sel = bs; imm = im; rd = r; rd_wren = w; a_sel = 1'b0;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    drive(o, a, b, 1'b0, 32'h0, 5'd1, 1'b1);
    step();
    chk(tag, alu_result, exp);
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_store", store_data, 32'd0);
    chk("rst_rd", {27'b0, rd_addr_q}, 32'd0);
    chk("rst_wren", {31'b0, rd_wren_q}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", {31'b0, in_ready}, 32'd1);
    drive(4'd7, 32'h8000_0000, 32'h0, 1'b1, 32'd4, 5'd3, 1'b1);
    step();
    chk("sra_valid", {31'b0, out_valid}, 32'd1);
    chk("sra_result", alu_result, 32'hF800_0000);
    chk("sra_rd", {27'b0, rd_addr_q}, 32'd3);
    chk("sra_wren", {31'b0, rd_wren_q}, 32'd1);
    alu_vec("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF);
    chk("sub_store", store_data, 32'h1);
    alu_vec("sltu_0_1", 4'd4, 32'h0, 32'h1, 32'h1);
    alu_vec("slt_neg", 4'd3, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_vec("sltu_big", 4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_vec("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_vec("sll_33", 4'd2, 32'h3, 32'h21, 32'h6);
    alu_vec("srl_4", 4'd6, 32'h8000_0000, 32'h4, 32'h0800_0000);
    alu_vec("sra_pos", 4'd7, 32'h7000_0000, 32'h4, 32'h0700_0000);
    alu_vec("xor", 4'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    alu_vec("or", 4'd8, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
    alu_vec("and", 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_vec("op12", 4'd12, 32'h1234, 32'h5678, 32'h0);
    drive(4'd10, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h1234_5000, 5'd0, 1'b1);
    step();
    chk("lui_result", alu_result, 32'h1234_5000);
    chk("lui_rd0_wren", {31'b0, rd_wren_q}, 32'd0);
    drive(4'd0, 32'h0, 32'h0, 1'b1, 32'd4, 5'd2, 1'b1);
    a_sel = 1'b1; pc = 32'h1000;
    step();
    chk("auipc_pc", alu_result, 32'h1004);
    alu_vec("stall_add", 4'd0, 32'd5, 32'd7, 32'd12);
    out_ready = 1'b0;
    drive(4'd5, 32'hF0, 32'hFF, 1'b0, 32'h0, 5'd4, 1'b1);
    #1;
    chk("stall_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", alu_result, 32'd12);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("after_stall", alu_result, 32'h0F);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    alu_vec("flush_pre", 4'd0, 32'd1, 32'd1, 32'd2);
    out_ready = 1'b0; flush = 1'b1;
    drive(4'd0, 32'd3, 32'd3, 1'b0, 32'h0, 5'd5, 1'b1);
    step();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_data", alu_result, 32'd2);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_vec("ar_pre", 4'd0, 32'd5, 32'd7, 32'd12);
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", alu_result, 32'd0);
    chk("arst_wren", {31'b0, rd_wren_q}, 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
`ifdef EX_FWD_EN
    drive(4'd0, 32'd1, 32'h0, 1'b1, 32'd2, 5'd6, 1'b1);
    fwd_a = 2'd1; mem_fwd = 32'h10;
    step();
    chk("fwd_mem_a", alu_result, 32'h12);
    drive(4'd0, 32'h100, 32'h55, 1'b1, 32'd8, 5'd0, 1'b0);
    fwd_a = 2'd0; fwd_b = 2'd2; wb_fwd = 32'hAB;
    step();
    chk("fwd_wb_store", store_data, 32'hAB);
    chk("fwd_store_addr", alu_result, 32'h108);
    fwd_b = 2'd0;
`endif
    in_valid = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
